// File: rtl/bsg_link_ddr_downstream_assembler_pkg.sv
// Shared DDR link helpers: flit width, SIPO ratio, token counter sizing.
package bsg_link_ddr_pkg;

  localparam int token_cnt_extra_gp = 1;

  function automatic int ddr_width(input int channel_width,
                                   input int extra_bit);
    return 2*channel_width + extra_bit;
  endfunction

  function automatic int sipo_els(input int width,
                                  input int ddr_w,
                                  input int num_ch);
    return width / (ddr_w*num_ch);
  endfunction

  function automatic int token_cnt_width(input int lg);
    return lg + token_cnt_extra_gp;
  endfunction

endpackage

// File: rtl/bsg_link_ddr_downstream_assembler_if.sv
// Channel-side FIFO heads and core-side word port of the downstream assembler.
interface bsg_link_ddr_downstream_assembler_if #(
  parameter int width_p        = 64,
  parameter int ddr_width_p    = 16,
  parameter int num_channels_p = 2
);

  logic [num_channels_p*ddr_width_p-1:0] core_ch_data_i;
  logic [num_channels_p-1:0]             core_ch_valid_i;
  logic [num_channels_p-1:0]             core_ch_yumi_o;
  logic [width_p-1:0]                    core_data_o;
  logic                                  core_valid_o;
  logic                                  core_yumi_i;

  modport slave (
    input  core_ch_data_i,
    input  core_ch_valid_i,
    input  core_yumi_i,
    output core_ch_yumi_o,
    output core_data_o,
    output core_valid_o
  );

  modport master (
    output core_ch_data_i,
    output core_ch_valid_i,
    output core_yumi_i,
    input  core_ch_yumi_o,
    input  core_data_o,
    input  core_valid_o
  );

endinterface

// File: rtl/bsg_link_ddr_downstream_assembler_token.sv
// Per-channel credit token generator: MSB of a free-running dequeue counter.
module bsg_link_token_toggle_gen
  import bsg_link_ddr_pkg::*;
#(
  parameter int lg_p = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic incr_i,
  output logic toggle_r_o
);

  localparam int cw_lp = token_cnt_width(lg_p);

  logic [cw_lp-1:0] r_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     r_cnt <= '0;
    else if (incr_i) r_cnt <= r_cnt + 1'b1;
  end

  assign toggle_r_o = r_cnt[cw_lp-1];

endmodule

// File: rtl/bsg_link_ddr_downstream_assembler.sv
// DDR link receive back-end: lock-step channel dequeue, SIPO word build, tokens.
// Optional skew checker enabled by BSG_LINK_DDR_DOWNSTREAM_ALIGN_CHECK_EN.
module bsg_link_ddr_downstream_assembler
  import bsg_link_ddr_pkg::*;
#(
  parameter int width_p                         = 64,
  parameter int channel_width_p                 = 8,
  parameter int num_channels_p                  = 2,
  parameter int lg_credit_to_token_decimation_p = 3,
  parameter int use_extra_data_bit_p            = 0,
  parameter int skew_limit_p                    = 16
) (
  input  logic                      core_clk_i,
  input  logic                      core_link_reset_i,
  bsg_link_ddr_downstream_assembler_if.slave io,
  output logic [num_channels_p-1:0] core_token_toggle_r_o,
  output logic                      core_skew_error_r_o
);

  localparam int ddr_width_lp =
    ddr_width(channel_width_p, use_extra_data_bit_p);
  localparam int slice_w_lp = ddr_width_lp*num_channels_p;
  localparam int els_lp =
    sipo_els(width_p, ddr_width_lp, num_channels_p);
  localparam int cnt_w_lp = (els_lp > 1) ? $clog2(els_lp) : 1;

  logic                w_deq;
  logic                w_last;
  logic [cnt_w_lp-1:0] r_cnt;
  logic [width_p-1:0]  r_stage;
  logic [width_p-1:0]  w_word;
  logic [width_p-1:0]  r_data;
  logic                r_valid;

  assign w_deq = (&io.core_ch_valid_i)
               & ~(r_valid & ~io.core_yumi_i);
  assign w_last = (r_cnt == cnt_w_lp'(els_lp-1));

  assign io.core_ch_yumi_o = {num_channels_p{w_deq}};
  assign io.core_data_o    = r_data;
  assign io.core_valid_o   = r_valid;

  // Staged slices plus the flit arriving now; the full word on completion.
  always_comb begin
    w_word = r_stage;
    w_word[int'(r_cnt)*slice_w_lp +: slice_w_lp] = io.core_ch_data_i;
  end

  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) begin
      r_cnt   <= '0;
      r_stage <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_deq) begin
        r_stage <= w_word;
        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
      end
      if (w_deq && w_last) begin
        r_data  <= w_word;
        r_valid <= 1'b1;
      end else if (io.core_yumi_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < num_channels_p; i++) begin : g_tok
    bsg_link_token_toggle_gen #(
      .lg_p(lg_credit_to_token_decimation_p)
    ) u_tok (
      .clk_i     (core_clk_i),
      .reset_i   (core_link_reset_i),
      .incr_i    (w_deq),
      .toggle_r_o(core_token_toggle_r_o[i])
    );
  end

`ifdef BSG_LINK_DDR_DOWNSTREAM_ALIGN_CHECK_EN
  localparam int skew_w_lp = $clog2(skew_limit_p+1);

  logic [skew_w_lp-1:0] r_skew_cnt;
  logic                 r_skew_err;
  logic                 w_partial;

  assign w_partial = (|io.core_ch_valid_i)
                   & ~(&io.core_ch_valid_i);

  always_ff @(posedge core_clk_i or posedge core_link_reset_i) begin
    if (core_link_reset_i) begin
      r_skew_cnt <= '0;
      r_skew_err <= 1'b0;
    end else begin
      if (!w_partial)
        r_skew_cnt <= '0;
      else if (r_skew_cnt != skew_w_lp'(skew_limit_p))
        r_skew_cnt <= r_skew_cnt + 1'b1;
      if (w_partial && r_skew_cnt == skew_w_lp'(skew_limit_p-1))
        r_skew_err <= 1'b1;
    end
  end

  assign core_skew_error_r_o = r_skew_err;
`else
  assign core_skew_error_r_o = (skew_limit_p < 0);
`endif

endmodule
